// File: rtl/proc_io_hub.sv
// Processor I/O hub: per-channel input FIFOs read by processor strobes, plus
// per-channel output holding registers. Optional sticky overflow flags via IO_HUB_OVF_EN.

module proc_io_hub_fifo #(
    parameter int DW     = 28,
    parameter int FDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    input  logic          rd_en,
    output logic          ready,
    output logic          empty,
    output logic          drop,
    output logic [DW-1:0] head
);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH + 1);

    logic [DW-1:0] mem [FDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    // Readiness comes only from the registered count, so a same-cycle pop never admits a push.
    assign ready = (count != CW'(FDEPTH));
    assign empty = (count == '0);
    assign push  = wr_valid & ready;
    assign pop   = rd_en & ~empty;
    assign drop  = wr_valid & ~ready;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module proc_io_hub #(
    parameter int NUIOIN = 4,
    parameter int NUIOOU = 4,
    parameter int DW     = 28,
    parameter int FDEPTH = 4,
    localparam int AIW   = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    localparam int AOW   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUIOIN*DW-1:0] ext_in_data,
    input  logic [NUIOIN-1:0]    ext_in_valid,
    output logic [NUIOIN-1:0]    ext_in_ready,
    input  logic                 proc_req_in,
    input  logic [AIW-1:0]       proc_addr_in,
    output logic [DW-1:0]        proc_din,
    output logic                 proc_stall,
    input  logic                 proc_out_en,
    input  logic [AOW-1:0]       proc_addr_out,
    input  logic [DW-1:0]        proc_dout,
    output logic [NUIOOU*DW-1:0] ext_out_data,
    output logic [NUIOOU-1:0]    ext_out_valid,
    output logic [NUIOIN-1:0]    req_in,
    output logic [NUIOIN-1:0]    ovf,
    input  logic [NUIOIN-1:0]    ovf_clr
);
    localparam logic [AIW:0] NIN  = (AIW + 1)'(NUIOIN);
    localparam logic [AOW:0] NOUT = (AOW + 1)'(NUIOOU);

    logic [NUIOIN-1:0][DW-1:0] head;
    logic [NUIOIN-1:0]         empty;
    logic [NUIOIN-1:0]         drop;
    logic                      in_ok, sel_empty, wr_ok;

    genvar i;
    generate
        for (i = 0; i < NUIOIN; i++) begin : g_in
            proc_io_hub_fifo #(.DW(DW), .FDEPTH(FDEPTH)) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .wr_data  (ext_in_data[i*DW +: DW]),
                .wr_valid (ext_in_valid[i]),
                .rd_en    (req_in[i]),
                .ready    (ext_in_ready[i]),
                .empty    (empty[i]),
                .drop     (drop[i]),
                .head     (head[i])
            );
        end
    endgenerate

    assign in_ok = ({1'b0, proc_addr_in} < NIN);

    always_comb begin
        proc_din  = '0;
        sel_empty = 1'b1;
        req_in    = '0;
        if (in_ok) begin
            sel_empty = empty[proc_addr_in];
            if (!sel_empty) begin
                proc_din = head[proc_addr_in];
                if (proc_req_in) req_in[proc_addr_in] = 1'b1;
            end
        end
    end

    assign proc_stall = proc_req_in & in_ok & sel_empty;

    // Output side: holding registers with a one-cycle update strobe per write.
    assign wr_ok = proc_out_en & ({1'b0, proc_addr_out} < NOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_out_data  <= '0;
            ext_out_valid <= '0;
        end else begin
            ext_out_valid <= '0;
            for (int o = 0; o < NUIOOU; o++) begin
                if (wr_ok && proc_addr_out == AOW'(o)) begin
                    ext_out_data[o*DW +: DW] <= proc_dout;
                    ext_out_valid[o]         <= 1'b1;
                end
            end
        end
    end

`ifdef IO_HUB_OVF_EN
    // Set on a dropped push wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= '0;
        end else begin
            for (int c = 0; c < NUIOIN; c++) begin
                if (drop[c])         ovf[c] <= 1'b1;
                else if (ovf_clr[c]) ovf[c] <= 1'b0;
            end
        end
    end
`else
    logic unused_ovf;
    assign ovf        = '0;
    assign unused_ovf = ^{ovf_clr, drop};
`endif
endmodule

// File: tb/tb_proc_io_hub.sv
// Directed + random bench for proc_io_hub against a queue-based reference model.
module tb_proc_io_hub;
    localparam int NI = 4, NO = 4, DW = 28, FD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI*DW-1:0]  ext_in_data;
    logic [NI-1:0]     ext_in_valid;
    logic [NI-1:0]     ext_in_ready;
    logic              proc_req_in;
    logic [1:0]        proc_addr_in;
    logic [DW-1:0]     proc_din;
    logic              proc_stall;
    logic              proc_out_en;
    logic [1:0]        proc_addr_out;
    logic [DW-1:0]     proc_dout;
    logic [NO*DW-1:0]  ext_out_data;
    logic [NO-1:0]     ext_out_valid;
    logic [NI-1:0]     req_in;
    logic [NI-1:0]     ovf;
    logic [NI-1:0]     ovf_clr;

    proc_io_hub #(.NUIOIN(NI), .NUIOOU(NO), .DW(DW), .FDEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .proc_req_in(proc_req_in), .proc_addr_in(proc_addr_in), .proc_din(proc_din),
        .proc_stall(proc_stall), .proc_out_en(proc_out_en), .proc_addr_out(proc_addr_out),
        .proc_dout(proc_dout), .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid),
        .req_in(req_in), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [DW-1:0]    q [NI][$];
    logic [NO*DW-1:0] m_out;
    logic [NO-1:0]    m_vld;
    logic [NI-1:0]    m_ovf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ext_in_valid = '0;
        proc_req_in  = 1'b0;
        proc_out_en  = 1'b0;
        ovf_clr      = '0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NI; c++) q[c].delete();
        m_out = '0;
        m_vld = '0;
        m_ovf = '0;
    endtask

    task automatic set_in(input int ch, input logic [DW-1:0] d);
        ext_in_data[ch*DW +: DW] = d;
        ext_in_valid[ch] = 1'b1;
    endtask

    // Compare all outputs with the model, advance the model, then step one clock.
    task automatic cycle();
        logic [NI-1:0]  e_rdy, e_req;
        logic [DW-1:0]  e_din;
        logic           e_stall;
        int             a;
        #1;
        a = int'(proc_addr_in);
        for (int c = 0; c < NI; c++) e_rdy[c] = (q[c].size() != FD);
        e_din   = (q[a].size() > 0) ? q[a][0] : '0;
        e_stall = proc_req_in && (q[a].size() == 0);
        e_req   = '0;
        if (proc_req_in && q[a].size() > 0) e_req[a] = 1'b1;
        chk("ready", ext_in_ready, e_rdy);
        chk("din", proc_din, e_din);
        chk("stall", proc_stall, e_stall);
        chk("req_in", req_in, e_req);
        chk("out_data", ext_out_data, m_out);
        chk("out_valid", ext_out_valid, m_vld);
        chk("ovf", ovf, m_ovf);
        if (e_req != 0) void'(q[a].pop_front());
        for (int c = 0; c < NI; c++) begin
            if (ext_in_valid[c]) begin
                if (e_rdy[c]) q[c].push_back(ext_in_data[c*DW +: DW]);
`ifdef IO_HUB_OVF_EN
                else m_ovf[c] = 1'b1;
`endif
            end
`ifdef IO_HUB_OVF_EN
            if (ovf_clr[c] && !(ext_in_valid[c] && !e_rdy[c])) m_ovf[c] = 1'b0;
`endif
        end
        m_vld = '0;
        if (proc_out_en && int'(proc_addr_out) < NO) begin
            m_out[int'(proc_addr_out)*DW +: DW] = proc_dout;
            m_vld[int'(proc_addr_out)] = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        rst = 1'b0;
        ext_in_data = '0;
        proc_addr_in = '0;
        proc_addr_out = '0;
        proc_dout = '0;
        idle();
        model_reset();
        #12;
        chk("rst_ready", ext_in_ready, 4'hF);
        chk("rst_out_data", ext_out_data, '0);
        chk("rst_out_valid", ext_out_valid, 4'h0);
        chk("rst_ovf", ovf, 4'h0);
        @(negedge clk);
        rst = 1'b1;

        // Read empty ch0 after reset: data 0, stall.
        proc_req_in = 1'b1; proc_addr_in = 2'd0;
        #1; chk("empty_ch0_din", proc_din, 28'h0); chk("empty_ch0_stall", proc_stall, 1'b1);
        cycle();

        // Two words through ch2.
        set_in(2, 28'hA1); cycle();
        set_in(2, 28'hA2); cycle();
        proc_req_in = 1'b1; proc_addr_in = 2'd2;
        #1; chk("ch2_rd1", proc_din, 28'hA1); chk("ch2_req1", req_in, 4'b0100);
        chk("ch2_stall1", proc_stall, 1'b0);
        cycle();
        proc_req_in = 1'b1; proc_addr_in = 2'd2;
        #1; chk("ch2_rd2", proc_din, 28'hA2); chk("ch2_req2", req_in, 4'b0100);
        cycle();

        // Overfill ch0: fifth push dropped.
        for (int k = 0; k < 5; k++) begin
            set_in(0, 28'hB0 + 28'(k));
            if (k == 4) begin #1; chk("ch0_full_ready", ext_in_ready[0], 1'b0); end
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            proc_req_in = 1'b1; proc_addr_in = 2'd0;
            #1; chk("ch0_order", proc_din, 28'hB0 + 28'(k));
            cycle();
        end

        // Empty ch3 read.
        proc_req_in = 1'b1; proc_addr_in = 2'd3;
        #1; chk("ch3_stall", proc_stall, 1'b1); chk("ch3_req", req_in, 4'b0000);
        cycle();
        #1; chk("ch3_ready", ext_in_ready[3], 1'b1);

        // Full ch1 with simultaneous push and pop.
        for (int k = 0; k < 4; k++) begin set_in(1, 28'hC0 + 28'(k)); cycle(); end
        set_in(1, 28'hCF); proc_req_in = 1'b1; proc_addr_in = 2'd1;
        #1; chk("ch1_pp_req", req_in, 4'b0010); chk("ch1_pp_ready", ext_in_ready[1], 1'b0);
        cycle();
        #1; chk("ch1_after_ready", ext_in_ready[1], 1'b1);
        for (int k = 1; k < 4; k++) begin
            proc_req_in = 1'b1; proc_addr_in = 2'd1;
            #1; chk("ch1_drain", proc_din, 28'hC0 + 28'(k));
            cycle();
        end
        proc_req_in = 1'b1; proc_addr_in = 2'd1;
        #1; chk("ch1_empty", proc_stall, 1'b1);
        cycle();

        // Output write to channel 1.
        proc_out_en = 1'b1; proc_addr_out = 2'd1; proc_dout = 28'h0ABCDEF;
        cycle();
        #1; chk("out_ch1_data", ext_out_data[DW +: DW], 28'h0ABCDEF);
        chk("out_ch1_valid", ext_out_valid, 4'b0010);
        cycle();
        #1; chk("out_valid_drop", ext_out_valid, 4'b0000);
        // Back-to-back writes keep the strobe high.
        proc_out_en = 1'b1; proc_addr_out = 2'd3; proc_dout = 28'h1234567; cycle();
        proc_out_en = 1'b1; proc_addr_out = 2'd3; proc_dout = 28'h7654321; cycle();
        #1; chk("b2b_valid", ext_out_valid, 4'b1000);
        cycle();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NI; c++)
                if ($urandom_range(0, 99) < 45) set_in(c, DW'($urandom));
            proc_req_in   = ($urandom_range(0, 99) < 50);
            proc_addr_in  = 2'($urandom);
            proc_out_en   = ($urandom_range(0, 99) < 30);
            proc_addr_out = 2'($urandom);
            proc_dout     = DW'($urandom);
            ovf_clr       = 4'($urandom);
            cycle();
        end

        // Asynchronous reset in the middle of a burst on ch0.
        set_in(0, 28'hD0); cycle();
        set_in(0, 28'hD1); cycle();
        proc_out_en = 1'b1; proc_addr_out = 2'd0; proc_dout = 28'h5A5A5A5; cycle();
        set_in(0, 28'hD2);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_ready", ext_in_ready, 4'hF);
        chk("mid_rst_out_data", ext_out_data, '0);
        chk("mid_rst_out_valid", ext_out_valid, 4'h0);
        chk("mid_rst_ovf", ovf, 4'h0);
        idle();
        proc_req_in = 1'b1; proc_addr_in = 2'd0;
        #1; chk("mid_rst_din", proc_din, 28'h0); chk("mid_rst_stall", proc_stall, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        idle();
        proc_req_in = 1'b1; proc_addr_in = 2'd0;
        cycle();
        for (int n = 0; n < 50; n++) begin
            for (int c = 0; c < NI; c++)
                if ($urandom_range(0, 99) < 60) set_in(c, DW'($urandom));
            proc_req_in  = ($urandom_range(0, 99) < 40);
            proc_addr_in = 2'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
